pcie_dma_rx_pktfifo: RTL
========================

# pcie_dma_rx_pktfifo

Parametrised store-and-forward receive packet FIFO between the PCIe endpoint's receive stream and the DMA engine. It generalises the fixed 64-bit DMA stream to a configurable data width and buffer depth. Only complete, error-free packets are released downstream: packets flagged poisoned (`err_fwd`) or ECRC-bad (`ecrc_err`), and packets larger than the buffer, are discarded and counted. The FIFO sits directly after the endpoint receive interface and feeds the DMA request decoder.

## Interface
- `dbits`, default 64: data width; one of 64, 128, 256. Strobe width is `dbits/8`.
- `log2_depth`, default 9: buffer depth in words, `2**log2_depth`; minimum 4.
- `i_clk`, input, 1: clock. One clock domain only.
- `i_rst`, input, 1: reset. Synchronous, active-high.
- `i_data`, input, dbits: receive data word.
- `i_strob`, input, dbits/8: byte strobes.
- `i_last`, input, 1: last word of the packet.
- `i_bar_hit`, input, 7: BAR hit. Bits [5:0] are BAR0..BAR5; bit [6] is the expansion ROM.
- `i_err_fwd`, input, 1: packet is poisoned. Sampled on every accepted word.
- `i_ecrc_err`, input, 1: ECRC error. Valid with `i_last`.
- `i_valid`, input, 1: the input word is valid.
- `o_ready`, output, 1: the FIFO accepts the input word.
- `o_data`, output, dbits: output data word.
- `o_strob`, output, dbits/8: output byte strobes.
- `o_last`, output, 1: last word of the output packet.
- `o_bar_hit`, output, 7: BAR hit of the output word.
- `o_valid`, output, 1: the output word is valid.
- `i_ready`, input, 1: the downstream block accepts the output word.
- `o_pkt_cnt`, output, log2_depth+1: number of committed packets not yet fully read.
- `o_drop_cnt`, output, 16: number of dropped packets. Saturates at 0xFFFF.

## Operation
- **Storage.** Each RAM entry holds {data, strob, last, bar_hit}, i.e. `dbits + dbits/8 + 8` bits.
- **Pointers.** Three pointers, each `log2_depth+1` bits wide with a wrap bit:
  - `wr_ptr`: speculative write pointer.
  - `cm_ptr`: committed write pointer.
  - `rd_ptr`: read pointer.
- **Packet error flag.** `pkt_err` is the OR of `i_err_fwd` over all accepted words of the current packet.
- **Write-side states (WR_IDLE, WR_PKT, WR_DROP):**
  - WR_IDLE → WR_PKT on an accepted word with `i_last=0`.
  - WR_PKT → WR_IDLE on an accepted word with `i_last=1`.
    - If `pkt_err | i_err_fwd | i_ecrc_err` is 0: commit, `cm_ptr <= wr_ptr+1`.
    - Otherwise: drop, `wr_ptr <= cm_ptr` and `o_drop_cnt++`.
  - A single-word packet (accepted in WR_IDLE with `i_last=1`) follows the same commit/drop rule and stays in WR_IDLE.
  - WR_PKT → WR_DROP when the FIFO is full and `rd_ptr == cm_ptr`, i.e. the current packet alone fills the buffer. On entry, `wr_ptr <= cm_ptr`.
  - WR_DROP → WR_IDLE on an accepted word with `i_last=1`; `o_drop_cnt++`.
- **`o_ready`.**
  - WR_DROP: `o_ready = 1`; words are accepted and discarded.
  - Otherwise: `o_ready = !full`, where full means `wr_ptr - rd_ptr == 2**log2_depth`.
- **Read side.**
  - Words are readable while `rd_ptr != cm_ptr`.
  - A one-entry output register holds the head word and prefetches the next one; it is a full-throughput skid.
  - `rd_ptr` advances on each RAM read.
- **`o_pkt_cnt`.** Increments on commit and decrements on output handshake with `o_last=1`. When both happen in the same cycle the count is unchanged.
- **Reset.** Pointers, state and counters are cleared. All outputs are 0 except `o_ready`, which is 1 from the first cycle after reset. A partially received packet is lost and is not counted as dropped.

## Timing
- **Commit latency.** Last word accepted in cycle N → `cm_ptr` updated at N+1 → RAM read at N+1 → first `o_valid` at N+2. The FIFO is empty before N.
- **Throughput.** One word per cycle on each side, concurrently.
- **Full FIFO.** A read and a write in the same cycle on a full FIFO are permitted: `o_ready` stays 0 in that cycle and rises the next cycle.
- **Output handshake.** `o_valid`, `o_data`, `o_strob`, `o_last` and `o_bar_hit` hold stable while `o_valid=1 & i_ready=0`.
- **Input handshake.** `o_ready` is combinational from registered state only. It does not depend on `i_valid`.
- **Drop and read in the same cycle.** The rewind of `wr_ptr` and a read may occur together; the read uses the `cm_ptr` from before the cycle.
- **Counter saturation.** `o_drop_cnt` holds at 0xFFFF.

## Structure
- **Shared package.** The following go in the existing PCIe DMA types package:
  - `PCIE_DMA_BAR_BITS = 7`.
  - Write-state enum `pcie_rxfifo_wr_state_type`.
- **Sub-module.** `pcie_dma_pktfifo_ram`: simple dual-port synchronous RAM, parameters `abits` and `dbits`, one write port and one read port, 1-cycle read latency, no reset of contents.
- **Top-level logic.** Write FSM, pointer arithmetic, counters and output register live in the top module.

## Test plan
1. Reset, then a 4-word packet with data 0x1..0x4 and `bar_hit=7'h01` → `o_valid` two cycles after `i_last`; 4 words out in order with `o_last` on 0x4; `o_pkt_cnt` goes 1→0.
2. 3-word packet with `i_err_fwd=1` on word 2, followed by a clean 2-word packet → only the 2-word packet is output; `o_drop_cnt=1`.
3. 2-word packet with `i_ecrc_err=1` on `i_last` → no output; `o_drop_cnt=1`; the buffer is fully reusable afterwards.
4. `log2_depth=4` with a 20-word packet and `i_ready=0` → `o_ready` stays 1 through WR_DROP; no output; `o_drop_cnt=1`; the next 3-word packet passes.
5. Back-to-back 8-word packets with `i_ready` toggling 1/0 randomly → lossless in-order data; `o_valid` is never dropped while `i_ready=0`; `o_ready` is low when full.
6. Assert `i_rst` in the middle of packet word 3 → the next cycle has `o_valid=0`, `o_pkt_cnt=0`, `o_drop_cnt=0`; a new packet passes normally.

Source files
------------

// File: rtl/pcie_dma_rx_pktfifo_pkg.sv
// rtl/pcie_dma_rx_pktfifo_pkg.sv - shared PCIe DMA types for the receive packet FIFO
package pcie_dma_rx_pktfifo_pkg;

  localparam int PCIE_DMA_BAR_BITS = 7;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_PKT  = 2'd1,
    WR_DROP = 2'd2
  } pcie_rxfifo_wr_state_type;

  // Counter increment that holds at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pcie_dma_pktfifo_ram.sv
// rtl/pcie_dma_pktfifo_ram.sv - simple dual-port synchronous RAM, 1-cycle read latency
// Ports: clk; write port wr_en/wr_addr/wr_data; read port rd_en/rd_addr,
// rd_data registered and held while rd_en is low. Contents are not reset.
module pcie_dma_pktfifo_ram #(
  parameter int abits = 9,
  parameter int dbits = 80
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [abits-1:0] wr_addr,
  input  logic [dbits-1:0] wr_data,
  input  logic             rd_en,
  input  logic [abits-1:0] rd_addr,
  output logic [dbits-1:0] rd_data
);

  logic [dbits-1:0] mem [2**abits];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/pcie_dma_rx_pktfifo.sv
// rtl/pcie_dma_rx_pktfifo.sv - store-and-forward receive packet FIFO, endpoint rx to DMA
// Ports: i_clk/i_rst (sync, active-high); input stream i_data/i_strob/i_last/
// i_bar_hit/i_err_fwd/i_ecrc_err/i_valid with o_ready; output stream o_data/
// o_strob/o_last/o_bar_hit/o_valid with i_ready; o_pkt_cnt committed packets
// not yet fully read; o_drop_cnt saturating count of discarded packets.
module pcie_dma_rx_pktfifo
  import pcie_dma_rx_pktfifo_pkg::*;
#(
  parameter int dbits      = 64,
  parameter int log2_depth = 9
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [dbits-1:0]             i_data,
  input  logic [dbits/8-1:0]           i_strob,
  input  logic                         i_last,
  input  logic [PCIE_DMA_BAR_BITS-1:0] i_bar_hit,
  input  logic                         i_err_fwd,
  input  logic                         i_ecrc_err,
  input  logic                         i_valid,
  output logic                         o_ready,
  output logic [dbits-1:0]             o_data,
  output logic [dbits/8-1:0]           o_strob,
  output logic                         o_last,
  output logic [PCIE_DMA_BAR_BITS-1:0] o_bar_hit,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [log2_depth:0]          o_pkt_cnt,
  output logic [15:0]                  o_drop_cnt
);

  localparam int SBITS = dbits / 8;
  localparam int EBITS = dbits + SBITS + 1 + PCIE_DMA_BAR_BITS;
  localparam int PBITS = log2_depth + 1;
  localparam logic [PBITS-1:0] DEPTH = {1'b1, {log2_depth{1'b0}}};

  pcie_rxfifo_wr_state_type state;
  logic [PBITS-1:0]         wr_ptr, cm_ptr, rd_ptr, used;
  logic                     pkt_err, out_valid;
  logic [log2_depth:0]      pkt_cnt;
  logic [15:0]              drop_cnt;
  logic                     full, accept, wr_en, pkt_bad, commit, overflow, rd_en, pop_last;
  logic [EBITS-1:0]         ram_wdata, ram_rdata;
  logic [dbits-1:0]         q_data;
  logic [SBITS-1:0]         q_strob;
  logic                     q_last;
  logic [PCIE_DMA_BAR_BITS-1:0] q_bar;

  // Occupancy counts only words still in RAM; the head word in the output
  // register has already been read out and is not part of it.
  assign used     = wr_ptr - rd_ptr;
  assign full     = (used == DEPTH);
  assign o_ready  = (state == WR_DROP) || !full;
  assign accept   = i_valid && o_ready;
  assign wr_en    = accept && (state != WR_DROP);
  assign pkt_bad  = pkt_err || i_err_fwd || i_ecrc_err;
  assign commit   = wr_en && i_last && !pkt_bad;
  // Packet alone fills the whole buffer: it can never complete, so discard it.
  assign overflow = (state == WR_PKT) && full && (rd_ptr == cm_ptr);
  // RAM read-data register is the output register; refill whenever it is
  // empty or being consumed this cycle.
  assign rd_en    = (rd_ptr != cm_ptr) && (!out_valid || i_ready);
  assign pop_last = out_valid && i_ready && q_last;

  assign ram_wdata = {i_data, i_strob, i_last, i_bar_hit};
  assign {q_data, q_strob, q_last, q_bar} = ram_rdata;

  pcie_dma_pktfifo_ram #(
    .abits (log2_depth),
    .dbits (EBITS)
  ) u_ram (
    .clk     (i_clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[log2_depth-1:0]),
    .wr_data (ram_wdata),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr[log2_depth-1:0]),
    .rd_data (ram_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= WR_IDLE;
      wr_ptr    <= '0;
      cm_ptr    <= '0;
      rd_ptr    <= '0;
      pkt_err   <= 1'b0;
      out_valid <= 1'b0;
      pkt_cnt   <= '0;
      drop_cnt  <= '0;
    end else begin
      case (state)
        WR_IDLE, WR_PKT: begin
          if (accept) begin
            if (i_last) begin
              state   <= WR_IDLE;
              pkt_err <= 1'b0;
              if (pkt_bad) begin
                wr_ptr   <= cm_ptr;
                drop_cnt <= sat_inc16(drop_cnt);
              end else begin
                wr_ptr <= wr_ptr + 1'b1;
                cm_ptr <= wr_ptr + 1'b1;
              end
            end else begin
              state   <= WR_PKT;
              pkt_err <= pkt_err || i_err_fwd;
              wr_ptr  <= wr_ptr + 1'b1;
            end
          end else if (overflow) begin
            state   <= WR_DROP;
            pkt_err <= 1'b0;
            wr_ptr  <= cm_ptr;
          end
        end
        WR_DROP: begin
          if (accept && i_last) begin
            state    <= WR_IDLE;
            drop_cnt <= sat_inc16(drop_cnt);
          end
        end
        default: state <= WR_IDLE;
      endcase

      if (rd_en) rd_ptr <= rd_ptr + 1'b1;

      if (rd_en)        out_valid <= 1'b1;
      else if (i_ready) out_valid <= 1'b0;

      case ({commit, pop_last})
        2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
        2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  // The RAM read register is not reset, so payload outputs are forced to
  // zero whenever no word is presented.
  assign o_valid    = out_valid;
  assign o_data     = out_valid ? q_data  : {dbits{1'b0}};
  assign o_strob    = out_valid ? q_strob : {SBITS{1'b0}};
  assign o_last     = out_valid && q_last;
  assign o_bar_hit  = out_valid ? q_bar   : {PCIE_DMA_BAR_BITS{1'b0}};
  assign o_pkt_cnt  = pkt_cnt;
  assign o_drop_cnt = drop_cnt;

endmodule
